sys_bus_reg_responder: RTL
==========================

Name: sys_bus_reg_responder

Overview:
- Generic sys_bus slave endpoint that answers the single-cycle wen/ren pulses an interconnect port issues toward one slave.
- Implements a bank of read/write control registers, a sticky write-1-to-clear status register, a raw status view, a write-strobe register and a dropped-request counter.
- Ack/err/rdata returned with fixed, parameterised latency.
- Sits behind one interconnect slave port, in the same clock domain as that port's side of the clock-domain crossing.

Parameters:
- SW, 20, slave address width; only addr[SW-1:0] is decoded.
- NREG, 8, number of 32-bit control registers (1..16).
- RD_LAT, 1, read latency ren->ack in cycles (1..4).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- sys_addr  in  32  bus address (byte).
- sys_wdata  in  32  write data.
- sys_wen  in  1  write request pulse.
- sys_ren  in  1  read request pulse.
- sys_rdata  out  32  read data, valid on ack cycle.
- sys_err  out  1  error, valid only with sys_ack.
- sys_ack  out  1  one-cycle acknowledge.
- ctrl_o  out  NREG*32  control registers, reg k at [32k+:32].
- sts_i  in  32  status event inputs (level, sampled each cycle).
- strobe_o  out  32  one-cycle copy of wdata written to STROBE.

Behaviour:
- Reset (rstn_i low at a clock edge): ctrl_o, sticky status, drop counter, strobe_o, sys_rdata, sys_err and sys_ack all set to 0. Any pending read is discarded and no ack is issued for it.
- Address map (offset = addr[SW-1:0]):
  - 0x00..4*(NREG-1): CTRL, R/W.
  - 0x40: STS_STICKY, R/W1C.
  - 0x44: STS_RAW, RO (sts_i).
  - 0x48: STROBE, WO, reads 0.
  - 0x4C: DROP_CNT, RO, bits[7:0], upper bits 0.
  - Anything else, or addr[1:0]!=0: error.
- Write (sys_wen=1, idle):
  - Register updates at that edge.
  - sys_ack=1 the next cycle, sys_err=0.
  - Error address: no state change, ack with err=1.
  - Write to a RO register: ack with err=1, no state change.
- Read (sys_ren=1, idle):
  - Read data is captured at request time.
  - sys_ack=1 exactly RD_LAT cycles later, with sys_rdata/sys_err.
  - Error address: rdata=0, err=1.
- sys_rdata holds its last read value until the next read ack. Write acks do not alter it.
- sys_wen and sys_ren high in the same cycle: no access performed; ack next cycle with err=1.
- Busy = read pending (cycles between ren and its ack). Any wen/ren arriving while busy is dropped: no ack, no state change, DROP_CNT +1, saturating at 255.
- Writes complete in one cycle and never cause busy. A request in the same cycle as a write ack is accepted.
- A read accepted in the same cycle as a previous read's ack is accepted (back-to-back at RD_LAT spacing is allowed).
- STS_STICKY:
  - Each cycle: sticky <= (sticky & ~clr) | sts_i.
  - clr = wdata on a valid write to 0x40, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- STROBE: a valid write drives strobe_o=wdata for exactly one cycle (the cycle after wen, coincident with ack); otherwise strobe_o=0.
- Internal state: IDLE, RD_WAIT (latency counter, 2 bits), tracked with a counter down to 1; ack emitted on the counter-expiry cycle, then return to IDLE.
- sys_ack is never asserted for two consecutive cycles for the same request.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 -> ack 1 cycle later, err=0; ctrl_o[63:32]=0xDEADBEEF; read 0x04 with RD_LAT=3 -> ack exactly 3 cycles after ren, rdata=0xDEADBEEF.
- Hold sts_i=0x5 for 1 cycle then 0 -> STS_STICKY reads 0x5 and STS_RAW reads 0. Write 0x1 to 0x40 -> reads 0x4. Write 0x4 while sts_i[2]=1 -> bit stays 1.
- Read 0x50, write 0x44, read 0x06 -> each acks with err=1; write to 0x44 leaves state unchanged; reads return 0.
- RD_LAT=2: ren to 0x00, then wen to 0x00 on the next cycle -> write dropped, ctrl unchanged, DROP_CNT=1. Repeat 300 times -> DROP_CNT=255.
- wen and ren in the same cycle at 0x00 -> ack next cycle with err=1, ctrl_o unchanged. Write 0x12345678 to 0x48 -> strobe_o=0x12345678 for one cycle only.
- Assert rstn_i low during RD_WAIT -> no ack issued; all outputs 0 on the following cycle; a subsequent read of 0x4C returns 0.

Source files
------------

// File: rtl/sys_bus_reg_responder.sv
// sys_bus slave endpoint: CTRL register bank, sticky/raw status, write strobe
// and a saturating dropped-request counter, answered with fixed latency.
module sys_bus_reg_responder #(
   parameter int SW     = 20,
   parameter int NREG   = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [31:0]          sys_addr,
   input  logic [31:0]          sys_wdata,
   input  logic                 sys_wen,
   input  logic                 sys_ren,
   output logic [31:0]          sys_rdata,
   output logic                 sys_err,
   output logic                 sys_ack,
   output logic [NREG*32-1:0]   ctrl_o,
   input  logic [31:0]          sts_i,
   output logic [31:0]          strobe_o
);

   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             cnt, cnt_nxt;
   logic [NREG-1:0][31:0]  ctrl_q;
   logic [31:0]            sticky_q;
   logic [31:0]            rd_hold_q;
   logic                   rd_hold_err_q;
   logic [7:0]             drop_q;

   logic [SW-1:0]          off;
   logic [31:0]            rd_data;
   logic                   rd_err, wr_err, sel_sts, sel_stb;
   logic [NREG-1:0]        sel_ctrl;
   logic                   idle, do_wr, do_rd, do_both, drop, rd_done, rd_fin;
   logic [31:0]            clr;
   logic                   unused_addr;

   assign off         = sys_addr[SW-1:0];
   assign unused_addr = ^sys_addr[31:SW];
   assign ctrl_o      = ctrl_q;

   // Requests are only honoured while no read is outstanding
   assign idle    = (state == IDLE);
   assign do_wr   = idle & sys_wen & ~sys_ren;
   assign do_rd   = idle & sys_ren & ~sys_wen;
   assign do_both = idle & sys_wen & sys_ren;
   assign drop    = ~idle & (sys_wen | sys_ren);
   assign rd_fin  = rd_done | (do_rd & (RD_LAT == 1));
   assign clr     = (do_wr & sel_sts) ? sys_wdata : 32'h0;

   // Address decode: read mux plus per-register write selects and error flags
   always_comb begin
      rd_data  = 32'h0;
      rd_err   = 1'b1;
      wr_err   = 1'b1;
      sel_sts  = 1'b0;
      sel_stb  = 1'b0;
      sel_ctrl = '0;
      for (int k = 0; k < NREG; k++) begin
         if (off == SW'(4 * k)) begin
            sel_ctrl[k] = 1'b1;
            rd_data     = ctrl_q[k];
            rd_err      = 1'b0;
            wr_err      = 1'b0;
         end
      end
      if (off == SW'(32'h40)) begin
         rd_data = sticky_q;
         rd_err  = 1'b0;
         wr_err  = 1'b0;
         sel_sts = 1'b1;
      end else if (off == SW'(32'h44)) begin
         rd_data = sts_i;
         rd_err  = 1'b0;
      end else if (off == SW'(32'h48)) begin
         rd_err  = 1'b0;
         wr_err  = 1'b0;
         sel_stb = 1'b1;
      end else if (off == SW'(32'h4C)) begin
         rd_data = {24'h0, drop_q};
         rd_err  = 1'b0;
      end
   end

   // Read-latency FSM state register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: count the read latency down to 1, finish the read on expiry
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (do_rd && (RD_LAT > 1)) begin
               state_nxt = RD_WAIT;
               cnt_nxt   = CNT_INIT;
            end
         end
         RD_WAIT: begin
            if (cnt == 2'd1) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registers, response path, sticky status, strobe and drop counter
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ctrl_q        <= '0;
         sticky_q      <= 32'h0;
         drop_q        <= 8'h0;
         strobe_o      <= 32'h0;
         sys_rdata     <= 32'h0;
         sys_err       <= 1'b0;
         sys_ack       <= 1'b0;
         rd_hold_q     <= 32'h0;
         rd_hold_err_q <= 1'b0;
      end else begin
         sys_ack <= do_wr | do_both | rd_fin;
         sys_err <= (do_wr & wr_err) | do_both
                  | (rd_fin & (rd_done ? rd_hold_err_q : rd_err));
         if (rd_fin)
            sys_rdata <= rd_done ? rd_hold_q : (rd_err ? 32'h0 : rd_data);
         // Snapshot taken at request time; error reads return zero
         if (do_rd) begin
            rd_hold_q     <= rd_err ? 32'h0 : rd_data;
            rd_hold_err_q <= rd_err;
         end
         for (int k = 0; k < NREG; k++)
            if (do_wr && sel_ctrl[k])
               ctrl_q[k] <= sys_wdata;
         // Set wins over a coincident clear
         sticky_q <= (sticky_q & ~clr) | sts_i;
         strobe_o <= (do_wr & sel_stb) ? sys_wdata : 32'h0;
         if (drop && (drop_q != 8'hFF))
            drop_q <= drop_q + 8'd1;
      end
   end

endmodule
